// File: rtl/quad_encoder_array.sv
// N_CH quadrature encoder front ends: 2-flop sync, shared-tick debounce, x1/x2/x4 decode,
// and bounded saturate/wrap position counters with per-channel load.
module quad_encoder_array #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 6,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 36,
  parameter int INIT_VAL  = 18,
  parameter int DEB_TICKS = 100000,
  localparam int LCH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       enc_a,
  input  logic [N_CH-1:0]       enc_b,
  input  logic [1:0]            mode,
  input  logic                  wrap_en,
  input  logic                  load,
  input  logic [LCH_W-1:0]      load_ch,
  input  logic [CNT_W-1:0]      load_val,
  output logic [N_CH*CNT_W-1:0] count,
  output logic [N_CH-1:0]       cw,
  output logic [N_CH-1:0]       ccw,
  output logic [N_CH-1:0]       err,
  output logic [N_CH-1:0]       at_min,
  output logic [N_CH-1:0]       at_max
);

  typedef enum logic [1:0] {
    RES_X1     = 2'd0,
    RES_X2     = 2'd1,
    RES_X4     = 2'd2,
    RES_X4_ALT = 2'd3
  } res_e;

  localparam int PRE_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_VAL);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_VAL);

  res_e             res;
  logic [PRE_W-1:0] pre;
  logic             tick;

  assign res  = res_e'(mode);
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  // Position along the clockwise cycle 11 -> 01 -> 00 -> 10.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b11:   return 2'd0;
      2'b01:   return 2'd1;
      2'b00:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
    if (int'(v) < MIN_VAL) return MIN_C;
    if (int'(v) > MAX_VAL) return MAX_C;
    return v;
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]       sync1, sync2, samp, db, prev, agree, dphase;
    logic [CNT_W-1:0] cnt;
    logic             chg, step_fwd, step_rev, step_bad, counted;
    logic             do_cw, do_ccw, ld_hit;
    logic             cw_q, ccw_q, err_q;

    always_comb begin
      agree    = ~(sync2 ^ samp);
      chg      = (prev != db);
      dphase   = phase(db) - phase(prev);
      step_fwd = chg && (dphase == 2'd1);
      step_rev = chg && (dphase == 2'd3);
      step_bad = chg && (dphase == 2'd2);
      counted  = 1'b1;
      case (res)
        RES_X1:  counted = ((prev == 2'b11) && (db == 2'b01)) ||
                           ((prev == 2'b01) && (db == 2'b11));
        RES_X2:  counted = prev[1] ^ db[1];
        default: counted = 1'b1;
      endcase
      do_cw  = step_fwd && counted;
      do_ccw = step_rev && counted;
      // Out-of-range load_ch values match no channel and are ignored.
      ld_hit = load && (load_ch == LCH_W'(g));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= '1;
        sync2 <= '1;
        samp  <= '1;
        db    <= '1;
        prev  <= '1;
        cnt   <= INIT_C;
        cw_q  <= 1'b0;
        ccw_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        sync1 <= {enc_a[g], enc_b[g]};
        sync2 <= sync1;
        prev  <= db;
        if (tick) begin
          samp <= sync2;
          db   <= (sync2 & agree) | (db & ~agree);
        end
        cw_q  <= do_cw;
        ccw_q <= do_ccw;
        err_q <= step_bad;
        if (ld_hit) begin
          cnt <= clamp_load(load_val);
        end else if (do_cw) begin
          cnt <= (cnt == MAX_C) ? (wrap_en ? MIN_C : MAX_C) : cnt + 1'b1;
        end else if (do_ccw) begin
          cnt <= (cnt == MIN_C) ? (wrap_en ? MAX_C : MIN_C) : cnt - 1'b1;
        end
      end
    end

    assign count[g*CNT_W +: CNT_W] = cnt;
    assign cw[g]     = cw_q;
    assign ccw[g]    = ccw_q;
    assign err[g]    = err_q;
    assign at_min[g] = (cnt == MIN_C);
    assign at_max[g] = (cnt == MAX_C);
  end

endmodule
